// File: rtl/inv_pipe_pkg.sv
// Shared types and defaults for the inverting-pipeline stimulus/checker block.
package inv_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Data width of the pipeline under test.
    localparam int DEF_WIDTH = 5;

endpackage : inv_pipe_pkg

// File: rtl/inv_pipe_stim_check_delay.sv
// Fixed-depth valid+data shift register used to line expected values up
// with the pipeline output. Only the valid bits are cleared; the data bits
// are meaningless whenever their valid bit is low.
module inv_pipe_delay
    import inv_pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_vld_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_vld_o,
    output logic [DW-1:0] out_data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Valid bits: cleared by reset or flush so nothing stale reaches the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data bits: free-running shift, qualified by the valid bits.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data_i;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_data_o = data_q[DEPTH-1];

endmodule : inv_pipe_delay

// File: rtl/inv_pipe_stim_check.sv
// Stimulus driver and response checker for a register/invert pipeline.
// Drives a Galois-LFSR vector sequence, checks each returned vector against
// the delayed inverse of what was driven, and reports pass/fail, error
// count, first failing index and a coverage flag for one target vector.
module inv_pipe_stim_check
    import inv_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               LATENCY = 2,
    parameter int               NUM_VEC = 10,
    parameter logic [WIDTH-1:0] TAPS    = 5'b10100,
    parameter logic [WIDTH-1:0] TARGET  = 5'b10101,
    localparam int              CNT_W   = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             cover_hit
);

    localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int PW    = WIDTH + CNT_W;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [7:0]       err_q, err_d;
    logic [CNT_W-1:0] ferr_q, ferr_d;
    logic             cover_q, cover_d;

    logic             start_acc;
    logic [WIDTH-1:0] seed_eff;
    logic             head_vld;
    logic [PW-1:0]    head_data;
    logic [WIDTH-1:0] head_exp;
    logic [CNT_W-1:0] head_idx;
    logic             chk_fail;
    logic             chk_ok;

    // One Galois step: shift right, fold the mask in when a 1 falls out.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // Saturating 8-bit increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign seed_eff  = (seed == '0) ? WIDTH'(1) : seed;

    // Expected value and index travel alongside the driven vector so that
    // they reach the comparator in the same cycle as the matching dut_out.
    inv_pipe_delay #(
        .DW    (PW),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (start_acc),
        .in_vld_i   (state_q == RUN),
        .in_data_i  ({~stim_q, idx_q}),
        .out_vld_o  (head_vld),
        .out_data_o (head_data)
    );

    assign head_exp = head_data[PW-1:CNT_W];
    assign head_idx = head_data[CNT_W-1:0];
    assign chk_fail = head_vld && (dut_out != head_exp);
    assign chk_ok   = head_vld && (dut_out == head_exp);

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            stim_q  <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            cover_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            stim_q  <= stim_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            cover_q <= cover_d;
        end
    end

    // Next-state logic: sequencing, LFSR advance and result accumulation.
    // The accepted-start edge already places the seed on stim, so stim shows
    // vector idx during RUN cycle idx and the last vector during the final
    // RUN cycle; lfsr_q always holds the vector to drive next.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        stim_d  = stim_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        cover_d = cover_q;

        if (chk_fail) begin
            err_d = sat_inc8(err_q);
            if (err_q == 8'd0) begin
                ferr_d = head_idx;
            end
        end
        if (chk_ok && (~head_exp == TARGET)) begin
            cover_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                stim_d = '0;
                if (start_acc) begin
                    state_d = RUN;
                    stim_d  = seed_eff;
                    lfsr_d  = lfsr_next(seed_eff);
                    idx_d   = '0;
                    drain_d = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    cover_d = 1'b0;
                end
            end
            RUN: begin
                if (idx_q == CNT_W'(NUM_VEC - 1)) begin
                    state_d = DRAIN;
                    stim_d  = '0;
                    drain_d = '0;
                end else begin
                    stim_d = lfsr_q;
                    lfsr_d = lfsr_next(lfsr_q);
                    idx_d  = idx_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                stim_d = '0;
                if (drain_q == DRN_W'(LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                stim_d  = '0;
            end
        endcase
    end

    assign stim          = stim_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (err_q == 8'd0);
    assign err_cnt       = err_q;
    assign first_err_idx = ferr_q;
    assign cover_hit     = cover_q;

endmodule : inv_pipe_stim_check

// File: tb/tb_inv_pipe_stim_check.sv
// Directed bench for inv_pipe_stim_check with a behavioural two-register
// inverting pipeline that can be switched to faulty variants.
module tb_inv_pipe_stim_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] seed = '0;
    logic [4:0] stim;
    logic [4:0] dut_out;
    logic       busy, done, pass, cover_hit;
    logic [7:0] err_cnt;
    logic [3:0] first_err_idx;

    int n_chk = 0;
    int n_err = 0;
    int mode  = 0;   // 0 correct, 1 output bit0 stuck at 0, 2 no inversion
    int bc;

    logic [4:0] p1, p2;

    // LFSR sequence from seed 1 with mask 10100, worked by hand.
    localparam logic [4:0] TBL [10] = '{5'h01, 5'h14, 5'h0A, 5'h05, 5'h16,
                                        5'h0B, 5'h11, 5'h1C, 5'h0E, 5'h07};

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        p1 <= stim;
        case (mode)
            1:       p2 <= ~p1 & 5'h1E;
            2:       p2 <= p1;
            default: p2 <= ~p1;
        endcase
    end
    assign dut_out = p2;

    inv_pipe_stim_check dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .seed          (seed),
        .stim          (stim),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .cover_hit     (cover_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and count busy cycles; optionally check the stim sequence
    // and pulse start again at busy cycle pulse_at.
    task automatic run(input logic [4:0] sd, input int md, input bit chk_seq,
                       input int pulse_at, output int bcnt);
        mode  = md;
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed  = 5'h0A;
        bcnt  = 0;
        while (busy && bcnt < 100) begin
            if (chk_seq && bcnt < 10) chk($sformatf("stim%0d", bcnt), stim, TBL[bcnt]);
            start = (bcnt == pulse_at);
            tick();
            bcnt++;
        end
        start = 1'b0;
        if (bcnt >= 100) chk("run_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #1;
        chk("rst_stim", stim, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ferr", first_err_idx, 0);
        chk("rst_cover", cover_hit, 0);
        #13 rst_n = 1'b1;
        tick();

        // Correct pipeline, seed 1
        run(5'h01, 0, 1'b1, -1, bc);
        chk("t1_busy_cycles", bc, 12);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_stim_idle", stim, 0);

        // Output bit0 stuck at 0: errors at idx 1,2,4,7,8
        run(5'h01, 1, 1'b1, -1, bc);
        chk("t2_busy_cycles", bc, 12);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_cnt, 5);
        chk("t2_ferr", first_err_idx, 1);

        // Seed 0 behaves as seed 1; start in DONE clears err_cnt
        run(5'h00, 0, 1'b1, -1, bc);
        chk("t3_busy_cycles", bc, 12);
        chk("t3_pass", pass, 1);
        chk("t3_err", err_cnt, 0);
        chk("t3_ferr", first_err_idx, 0);

        // TARGET vector driven first; cover visible after its check cycle
        mode  = 0;
        seed  = 5'h15;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_stim_target", stim, 5'h15);
        tick();
        chk("t4_cover_early", cover_hit, 0);
        tick();
        tick();
        chk("t4_cover_set", cover_hit, 1);
        wait_done();
        chk("t4_pass", pass, 1);
        chk("t4_cover_end", cover_hit, 1);

        // Inversion removed: every vector fails, cover never set
        run(5'h15, 2, 1'b0, -1, bc);
        chk("t4n_cover", cover_hit, 0);
        chk("t4n_err", err_cnt, 10);
        chk("t4n_ferr", first_err_idx, 0);
        chk("t4n_pass", pass, 0);

        // start pulsed mid-RUN is ignored
        run(5'h01, 0, 1'b1, 3, bc);
        chk("t5_busy_cycles", bc, 12);
        chk("t5_pass", pass, 1);

        // start in DONE after a failing run clears results and restarts next cycle
        run(5'h01, 1, 1'b0, -1, bc);
        chk("t5_pre_err", err_cnt, 5);
        mode  = 0;
        seed  = 5'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_rs_err", err_cnt, 0);
        chk("t5_rs_ferr", first_err_idx, 0);
        chk("t5_rs_done", done, 0);
        chk("t5_rs_busy", busy, 1);
        chk("t5_rs_stim", stim, 5'h01);
        wait_done();
        chk("t5_rs_pass", pass, 1);

        // Reset asserted in the first DRAIN cycle of a failing run
        mode  = 1;
        seed  = 5'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("t6_in_drain", busy, 1);
        chk("t6_pre_err", err_cnt, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_stim", stim, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_pass", pass, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_ferr", first_err_idx, 0);
        chk("t6_cover", cover_hit, 0);
        mode = 2;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        run(5'h01, 0, 1'b1, -1, bc);
        chk("t6_busy_cycles", bc, 12);
        chk("t6_post_pass", pass, 1);
        chk("t6_post_err", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_inv_pipe_stim_check
